// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the MEM-stage access controller.
package mem_stage_pkg;

    localparam int WORD_W = 32;
    localparam int REGN_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Clear/increment cycle counter with terminal-count flag for the REQ timeout.
// MAX=0 freezes the counter at zero and holds tc low.
module mem_timeout_cnt #(
    parameter int MAX   = 64,
    parameter int CNT_W = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && MAX != 0)
            cnt <= cnt + 1'b1;
    end

    // tc marks the last REQ cycle allowed before the access is abandoned
    assign tc = (MAX != 0) && (cnt == CNT_W'(MAX - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: req/ready handshake to a variable-latency data memory.
// Optional alignment check enabled by defining MEM_ALIGN_CHK_EN.
module mem_access_ctrl
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic [WORD_W-1:0] alu_out,
    input  logic [WORD_W-1:0] wdata,
    input  logic [REGN_W-1:0] rfile_wn,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [WORD_W-1:0] dmem_addr,
    output logic [WORD_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [WORD_W-1:0] dmem_rdata_in,
    output logic              out_MemtoReg,
    output logic              out_RegWrite,
    output logic [WORD_W-1:0] out_alu_out,
    output logic [WORD_W-1:0] out_dmem_rdata,
    output logic [REGN_W-1:0] out_rfile_wn,
    output logic              mem_stall,
    output logic              mem_err
);

    mem_state_t        state, state_nxt;
    logic              acc, misalign, tc;
    logic              err, rd_q;
    logic [WORD_W-1:0] rbuf;

    assign acc = MemRead | MemWrite;

`ifdef MEM_ALIGN_CHK_EN
    assign misalign = (alu_out[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    mem_timeout_cnt #(
        .MAX   (TIMEOUT_CYC),
        .CNT_W (CNT_W)
    ) u_tmo (
        .clk (clk),
        .rst (rst),
        .clr (state == IDLE && acc),
        .inc (state == REQ && !dmem_ready),
        .tc  (tc)
    );

    always_comb begin
        state_nxt = state;
        mem_stall = 1'b0;
        case (state)
            IDLE: begin
                mem_stall = acc;
                if (acc)
                    state_nxt = misalign ? DONE : REQ;
            end
            REQ: begin
                mem_stall = 1'b1;
                if (dmem_ready || tc)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            rbuf       <= '0;
            err        <= 1'b0;
            rd_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc && misalign) begin
                        err <= 1'b1;
                    end else if (acc) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= MemWrite;
                        dmem_addr  <= alu_out;
                        dmem_wdata <= wdata;
                        // read+write together behaves as a store that clears the buffer
                        rd_q       <= MemRead & ~MemWrite;
                        if (MemRead && MemWrite)
                            rbuf <= '0;
                    end
                end
                REQ: begin
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        if (rd_q)
                            rbuf <= dmem_rdata_in;
                    end else if (tc) begin
                        dmem_req <= 1'b0;
                        rbuf     <= '0;
                        err      <= 1'b1;
                    end
                end
                DONE:    err <= 1'b0;
                default: err <= 1'b0;
            endcase
        end
    end

    assign mem_err        = (state == DONE) && err;
    assign out_RegWrite   = RegWrite && !mem_err;
    assign out_MemtoReg   = MemtoReg;
    assign out_alu_out    = alu_out;
    assign out_rfile_wn   = rfile_wn;
    assign out_dmem_rdata = rbuf;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a transaction-level reference model.
module tb_mem_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite, MemtoReg, RegWrite;
    logic [31:0] alu_out, wdata, dmem_rdata_in;
    logic [4:0]  rfile_wn;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        out_MemtoReg, out_RegWrite, mem_stall, mem_err;
    logic [31:0] out_alu_out, out_dmem_rdata;
    logic [4:0]  out_rfile_wn;

    int nvec = 0;
    int nerr = 0;

    mem_access_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(7)) dut (
        .clk(clk), .rst(rst),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .alu_out(alu_out), .wdata(wdata), .rfile_wn(rfile_wn),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata_in(dmem_rdata_in),
        .out_MemtoReg(out_MemtoReg), .out_RegWrite(out_RegWrite), .out_alu_out(out_alu_out),
        .out_dmem_rdata(out_dmem_rdata), .out_rfile_wn(out_rfile_wn),
        .mem_stall(mem_stall), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one access at a time, tracked as "waiting for memory"
    // and "result being handed to MEM/WB", plus the captured request.
    bit          m_wait, m_fin, m_err, m_rd, m_we, acc_v;
    int          m_cnt;
    logic [31:0] m_addr, m_wd, m_rbuf;

    always @(negedge clk) begin
        if (rst) begin
            m_wait = 0; m_fin = 0; m_err = 0; m_cnt = 0; m_rbuf = 32'h0;
        end else begin
            acc_v = MemRead | MemWrite;
            chk("mem_stall", {31'b0, mem_stall}, m_fin ? 32'd0 : (m_wait ? 32'd1 : {31'b0, acc_v}));
            chk("dmem_req", {31'b0, dmem_req}, {31'b0, m_wait});
            if (m_wait) begin
                chk("dmem_addr", dmem_addr, m_addr);
                chk("dmem_we", {31'b0, dmem_we}, {31'b0, m_we});
                chk("dmem_wdata", dmem_wdata, m_wd);
            end
            chk("out_alu_out", out_alu_out, alu_out);
            chk("out_rfile_wn", {27'b0, out_rfile_wn}, {27'b0, rfile_wn});
            chk("out_MemtoReg", {31'b0, out_MemtoReg}, {31'b0, MemtoReg});
            chk("out_RegWrite", {31'b0, out_RegWrite}, {31'b0, RegWrite & !(m_fin && m_err)});
            chk("mem_err", {31'b0, mem_err}, {31'b0, m_fin && m_err});
            chk("out_dmem_rdata", out_dmem_rdata, m_rbuf);
            if (m_fin) begin
                m_fin = 0; m_err = 0;
            end else if (m_wait) begin
                if (dmem_ready) begin
                    if (m_rd) m_rbuf = dmem_rdata_in;
                    m_wait = 0; m_fin = 1;
                end else begin
                    m_cnt++;
                    if (TO != 0 && m_cnt == TO) begin
                        m_rbuf = 32'h0; m_err = 1; m_wait = 0; m_fin = 1;
                    end
                end
            end else if (acc_v) begin
`ifdef MEM_ALIGN_CHK_EN
                if (alu_out[1:0] != 2'b00) begin
                    m_fin = 1; m_err = 1;
                end else
`endif
                begin
                    m_wait = 1; m_cnt = 0;
                    m_addr = alu_out; m_we = MemWrite; m_wd = wdata;
                    m_rd = MemRead & !MemWrite;
                    if (MemRead && MemWrite) m_rbuf = 32'h0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Called just after a rising edge; ready_at = REQ cycle (1-based) that sees
    // dmem_ready, 0 for never. Checks stall length and DONE outputs literally.
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wd, input logic rw,
                              input int ready_at, input logic [31:0] rdata, input int exp_stalls,
                              input logic exp_err, input logic [31:0] exp_rdata, input logic exp_rw);
        int  i = 0;
        int  stalls = 0;
        bit  done = 0;
        MemRead = rd; MemWrite = wr; alu_out = addr; wdata = wd; RegWrite = rw;
        MemtoReg = rd; rfile_wn = addr[6:2];
        while (!done && i < 100) begin
            dmem_ready = (ready_at != 0 && i == ready_at);
            dmem_rdata_in = rdata;
            @(negedge clk);
            if (!mem_stall) begin
                done = 1;
            end else begin
                stalls++;
                if (i == 1) begin
                    chk({tag, "_req_addr"}, dmem_addr, addr);
                    chk({tag, "_req_we"}, {31'b0, dmem_we}, {31'b0, wr});
                end
                step();
                i++;
            end
        end
        chk({tag, "_stall_cycles"}, stalls, exp_stalls);
        chk({tag, "_done_err"}, {31'b0, mem_err}, {31'b0, exp_err});
        chk({tag, "_done_rdata"}, out_dmem_rdata, exp_rdata);
        chk({tag, "_done_regwrite"}, {31'b0, out_RegWrite}, {31'b0, exp_rw});
        step();
        MemRead = 0; MemWrite = 0; dmem_ready = 0; RegWrite = 0; MemtoReg = 0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; MemRead = 0; MemWrite = 0; MemtoReg = 0; RegWrite = 0;
        alu_out = 0; wdata = 0; rfile_wn = 0; dmem_ready = 0; dmem_rdata_in = 0;
        #2;
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_rdata", out_dmem_rdata, 32'h0);
        chk("rst_stall", {31'b0, mem_stall}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 0;

        // pass-through with stray ready: no stall, no request
        alu_out = 32'h1234; RegWrite = 1; rfile_wn = 5'd7; dmem_ready = 1;
        #1;
        chk("pt_alu_out", out_alu_out, 32'h1234);
        chk("pt_stall", {31'b0, mem_stall}, 32'd0);
        repeat (3) step();
        dmem_ready = 0; RegWrite = 0;
        step();

        run_access("load", 1, 0, 32'h40, 32'h0, 1, 3, 32'hDEADBEEF, 4, 0, 32'hDEADBEEF, 1);
        run_access("store", 0, 1, 32'h80, 32'hA5A5A5A5, 0, 1, 32'h11111111, 2, 0, 32'hDEADBEEF, 0);
        run_access("tmo", 1, 0, 32'h44, 32'h0, 1, 0, 32'h0, 5, 1, 32'h0, 0);
        run_access("load2", 1, 0, 32'h48, 32'h0, 1, 2, 32'h12345678, 3, 0, 32'h12345678, 1);
        run_access("rdwr", 1, 1, 32'h4C, 32'h55AA55AA, 1, 1, 32'hFFFF0000, 2, 0, 32'h0, 1);
`ifdef MEM_ALIGN_CHK_EN
        run_access("align", 1, 0, 32'h42, 32'h0, 1, 1, 32'h0BADF00D, 1, 1, 32'h0, 0);
`else
        run_access("unalign", 1, 0, 32'h42, 32'h0, 1, 1, 32'h0BADF00D, 2, 0, 32'h0BADF00D, 1);
`endif

        // reset in the middle of a request
        MemRead = 1; alu_out = 32'h100; RegWrite = 1;
        step(); step();
        #1;
        rst = 1;
        #1;
        chk("mid_rst_req", {31'b0, dmem_req}, 32'd0);
        chk("mid_rst_addr", dmem_addr, 32'h0);
        chk("mid_rst_stall", {31'b0, mem_stall}, 32'd1);
        step();
        rst = 0;
        #1;
        chk("post_rst_stall_acc", {31'b0, mem_stall}, 32'd1);
        MemRead = 0;
        #1;
        chk("post_rst_stall_idle", {31'b0, mem_stall}, 32'd0);
        chk("post_rst_rdata", out_dmem_rdata, 32'h0);
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
